// File: rtl/uart_tx_dds_core.sv
// Baud-tick generator, FWFT-FIFO-fed UART transmitter and quadrature DDS sine source.
// All outputs are registered; the FSM and DDS run on the rising edge of clk_50m.
module uart_tx_dds_core #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic [7:0]  din,
  input  logic        wr_en,
  output logic        read_fifo_flag,
  output logic        tx,
  output logic        tx_busy,
  output logic        txclk_en,
  output logic        rxclk_en,
  input  logic [31:0] freq_tuning_word,
  input  logic        phase_accumulator_reset,
  output logic [7:0]  dac_data,
  output logic [7:0]  q_dac_data
);

  localparam int unsigned TX_DIV   = CLK_FREQ / BAUD;
  localparam int unsigned RX_DIV   = CLK_FREQ / (BAUD * 16);
  localparam int unsigned TX_CNT_W = $clog2(TX_DIV);
  localparam int unsigned RX_CNT_W = $clog2(RX_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic [TX_CNT_W-1:0] tx_cnt;
  logic [RX_CNT_W-1:0] rx_cnt;
  logic                tx_tick_c;
  logic                rx_tick_c;

  tx_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;

  logic [31:0] phase;
  logic [7:0]  i_addr_c;
  logic [7:0]  q_addr_c;

  // The edge that raises a tick is also the edge the FSM acts on, so pops line up with txclk_en.
  assign tx_tick_c = (tx_cnt == '0);
  assign rx_tick_c = (rx_cnt == '0);

  // Baud and 16x oversample dividers
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      txclk_en <= 1'b0;
      rxclk_en <= 1'b0;
    end else begin
      txclk_en <= tx_tick_c;
      rxclk_en <= rx_tick_c;
      tx_cnt   <= (tx_cnt == TX_CNT_W'(TX_DIV - 1)) ? '0 : tx_cnt + TX_CNT_W'(1);
      rx_cnt   <= (rx_cnt == RX_CNT_W'(RX_DIV - 1)) ? '0 : rx_cnt + RX_CNT_W'(1);
    end
  end

  // Transmit FSM: start bit, 8 data bits LSB first, stop bit; STOP may chain straight into a new frame
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      shreg          <= '0;
      bit_idx        <= '0;
      tx             <= 1'b1;
      tx_busy        <= 1'b0;
      read_fifo_flag <= 1'b0;
    end else begin
      read_fifo_flag <= 1'b0;
      if (tx_tick_c) begin
        case (state)
          IDLE, STOP: begin
            if (wr_en) begin
              shreg          <= din;
              read_fifo_flag <= 1'b1;
              tx             <= 1'b0;
              tx_busy        <= 1'b1;
              state          <= START;
            end else begin
              tx      <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end
          START: begin
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Quarter-wave magnitude round(127*sin(2*pi*k/256)) for k = 0..64
  function automatic logic [6:0] quarter_sine(input logic [6:0] k);
    logic [6:0] m;
    case (k)
      7'd0:  m = 7'd0;   7'd1:  m = 7'd3;   7'd2:  m = 7'd6;   7'd3:  m = 7'd9;
      7'd4:  m = 7'd12;  7'd5:  m = 7'd16;  7'd6:  m = 7'd19;  7'd7:  m = 7'd22;
      7'd8:  m = 7'd25;  7'd9:  m = 7'd28;  7'd10: m = 7'd31;  7'd11: m = 7'd34;
      7'd12: m = 7'd37;  7'd13: m = 7'd40;  7'd14: m = 7'd43;  7'd15: m = 7'd46;
      7'd16: m = 7'd49;  7'd17: m = 7'd51;  7'd18: m = 7'd54;  7'd19: m = 7'd57;
      7'd20: m = 7'd60;  7'd21: m = 7'd63;  7'd22: m = 7'd65;  7'd23: m = 7'd68;
      7'd24: m = 7'd71;  7'd25: m = 7'd73;  7'd26: m = 7'd76;  7'd27: m = 7'd78;
      7'd28: m = 7'd81;  7'd29: m = 7'd83;  7'd30: m = 7'd85;  7'd31: m = 7'd88;
      7'd32: m = 7'd90;  7'd33: m = 7'd92;  7'd34: m = 7'd94;  7'd35: m = 7'd96;
      7'd36: m = 7'd98;  7'd37: m = 7'd100; 7'd38: m = 7'd102; 7'd39: m = 7'd104;
      7'd40: m = 7'd106; 7'd41: m = 7'd107; 7'd42: m = 7'd109; 7'd43: m = 7'd111;
      7'd44: m = 7'd112; 7'd45: m = 7'd113; 7'd46: m = 7'd115; 7'd47: m = 7'd116;
      7'd48: m = 7'd117; 7'd49: m = 7'd118; 7'd50: m = 7'd120; 7'd51: m = 7'd121;
      7'd52: m = 7'd122; 7'd53: m = 7'd122; 7'd54: m = 7'd123; 7'd55: m = 7'd124;
      7'd56: m = 7'd125; 7'd57: m = 7'd125; 7'd58: m = 7'd126; 7'd59: m = 7'd126;
      7'd60: m = 7'd126; 7'd61: m = 7'd127; 7'd62: m = 7'd127; 7'd63: m = 7'd127;
      default: m = 7'd127;
    endcase
    return m;
  endfunction

  // Full-wave offset-binary sample built from quarter-wave symmetry
  function automatic logic [7:0] sine_lut(input logic [7:0] a);
    logic [6:0] idx;
    logic [6:0] mag;
    idx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
    mag = quarter_sine(idx);
    return a[7] ? (8'd128 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
  endfunction

  assign i_addr_c = phase[31:24];
  assign q_addr_c = phase[31:24] + 8'd64;

  // DDS accumulator; the lookup uses the pre-update phase, giving one clock of latency
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      phase      <= '0;
      dac_data   <= 8'd128;
      q_dac_data <= 8'd255;
    end else begin
      phase      <= phase_accumulator_reset ? '0 : phase + freq_tuning_word;
      dac_data   <= sine_lut(i_addr_c);
      q_dac_data <= sine_lut(q_addr_c);
    end
  end

endmodule

// File: tb/tb_uart_tx_dds_core.sv
// Directed bench for uart_tx_dds_core: baud ticks, UART framing with a FWFT FIFO model, DDS samples.
`timescale 1ns/1ps
module tb_uart_tx_dds_core;

  logic        clk_50m = 1'b0;
  logic        reset;
  logic [7:0]  din = 8'h00;
  logic        wr_en = 1'b0;
  logic        read_fifo_flag;
  logic        tx;
  logic        tx_busy;
  logic        txclk_en;
  logic        rxclk_en;
  logic [31:0] freq_tuning_word;
  logic        phase_accumulator_reset;
  logic [7:0]  dac_data;
  logic [7:0]  q_dac_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fifo_q[$];
  int         pop_times[$];
  int         cyc = 0;
  int         flag_long = 0;
  logic       prev_flag = 1'b0;

  uart_tx_dds_core dut (
    .clk_50m                 (clk_50m),
    .reset                   (reset),
    .din                     (din),
    .wr_en                   (wr_en),
    .read_fifo_flag          (read_fifo_flag),
    .tx                      (tx),
    .tx_busy                 (tx_busy),
    .txclk_en                (txclk_en),
    .rxclk_en                (rxclk_en),
    .freq_tuning_word        (freq_tuning_word),
    .phase_accumulator_reset (phase_accumulator_reset),
    .dac_data                (dac_data),
    .q_dac_data              (q_dac_data)
  );

  always #10 clk_50m = ~clk_50m;

  // FWFT FIFO model: pop on the strobe, then present the new head
  always @(posedge clk_50m) begin
    #2;
    if (read_fifo_flag && fifo_q.size() > 0) void'(fifo_q.pop_front());
    wr_en = (fifo_q.size() > 0);
    din   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  // Pop-strobe monitor on the falling edge
  always @(negedge clk_50m) begin
    cyc = cyc + 1;
    if (read_fifo_flag) begin
      pop_times.push_back(cyc);
      if (prev_flag) flag_long = flag_long + 1;
    end
    prev_flag = read_fifo_flag;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  int n, err, busy_cnt, low_cnt, tx_bad, base;
  logic [9:0] frame_a5;
  logic [7:0] exp_i[4];
  logic [7:0] exp_q[4];

  initial begin
    reset = 1'b1;
    freq_tuning_word = 32'h0;
    phase_accumulator_reset = 1'b0;
    frame_a5 = 10'b11_0100_1010;
    exp_i[0] = 8'd128; exp_i[1] = 8'd255; exp_i[2] = 8'd128; exp_i[3] = 8'd1;
    exp_q[0] = 8'd255; exp_q[1] = 8'd128; exp_q[2] = 8'd1;   exp_q[3] = 8'd128;

    // Reset state
    step(); step(); step();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_txclk", 32'(txclk_en), 32'd0);
    check("rst_rxclk", 32'(rxclk_en), 32'd0);
    check("rst_flag", 32'(read_fifo_flag), 32'd0);
    check("rst_dac", 32'(dac_data), 32'd128);
    check("rst_qdac", 32'(q_dac_data), 32'd255);

    // Idle baud ticks
    reset = 1'b0;
    step();
    check("first_tick", 32'(txclk_en), 32'd1);
    n = 0; tx_bad = 0;
    do begin
      step(); n++;
      if (tx !== 1'b1) tx_bad++;
    end while (!txclk_en && n < 1000);
    check("tx_period", 32'(n), 32'd434);
    check("idle_tx_high", 32'(tx_bad), 32'd0);
    n = 0;
    do begin step(); n++; end while (!rxclk_en && n < 100);
    n = 0;
    do begin step(); n++; end while (!rxclk_en && n < 100);
    check("rx_period", 32'(n), 32'd27);
    check("idle_no_pop", 32'(pop_times.size()), 32'd0);

    // Single 0xA5 frame
    base = pop_times.size();
    fifo_q.push_back(8'hA5);
    n = 0;
    do begin step(); n++; end while (!txclk_en && n < 1000);
    check("pop_with_tick", 32'(read_fifo_flag), 32'd1);
    busy_cnt = 0;
    for (int b = 0; b < 10; b++) begin
      err = 0;
      for (int c = 0; c < 434; c++) begin
        if (tx !== frame_a5[b]) err++;
        if (tx_busy) busy_cnt++;
        step();
      end
      check($sformatf("a5_bit%0d", b), 32'(err), 32'd0);
    end
    check("a5_busy_len", 32'(busy_cnt), 32'd4340);
    check("a5_busy_end", 32'(tx_busy), 32'd0);
    check("a5_pops", 32'(pop_times.size() - base), 32'd1);

    // Back-to-back 0x00 then 0xFF
    base = pop_times.size();
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    n = 0;
    do begin step(); n++; end while (!read_fifo_flag && n < 1000);
    check("b2b_first_pop", 32'(read_fifo_flag), 32'd1);
    busy_cnt = 0; low_cnt = 0;
    for (int c = 0; c < 8680; c++) begin
      if (!tx_busy) busy_cnt++;
      if (!tx) low_cnt++;
      step();
    end
    check("b2b_no_gap", 32'(busy_cnt), 32'd0);
    check("b2b_tx_low", 32'(low_cnt), 32'd4340);
    check("b2b_busy_end", 32'(tx_busy), 32'd0);
    check("b2b_pops", 32'(pop_times.size() - base), 32'd2);
    if (pop_times.size() - base == 2)
      check("b2b_pop_gap", 32'(pop_times[base+1] - pop_times[base]), 32'd4340);

    // Reset during data bit 3
    fifo_q.push_back(8'h5A);
    n = 0;
    do begin step(); n++; end while (!read_fifo_flag && n < 1000);
    repeat (4 * 434 + 200) step();
    check("mid_busy", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("async_tx", 32'(tx), 32'd1);
    check("async_busy", 32'(tx_busy), 32'd0);
    base = pop_times.size();
    fifo_q.push_back(8'h33);
    step(); step();
    check("rst_no_pop", 32'(pop_times.size() - base), 32'd0);
    reset = 1'b0;
    step();
    check("pop_after_rel", 32'(read_fifo_flag), 32'd1);
    check("tick_after_rel", 32'(txclk_en), 32'd1);

    // DDS quarter-turn sequence
    reset = 1'b1;
    freq_tuning_word = 32'h4000_0000;
    step();
    reset = 1'b0;
    for (int r = 0; r < 8; r++) begin
      step();
      check($sformatf("dds_i%0d", r), 32'(dac_data), 32'(exp_i[r % 4]));
      check($sformatf("dds_q%0d", r), 32'(q_dac_data), 32'(exp_q[r % 4]));
    end

    // Ramp, accumulator clear, then ftw=0 hold
    freq_tuning_word = 32'h0100_0000;
    repeat (100) step();
    phase_accumulator_reset = 1'b1;
    step();
    phase_accumulator_reset = 1'b0;
    step();
    check("par_dac", 32'(dac_data), 32'd128);
    check("par_qdac", 32'(q_dac_data), 32'd255);
    step();
    check("ramp1_dac", 32'(dac_data), 32'd131);
    check("ramp1_qdac", 32'(q_dac_data), 32'd255);
    step();
    check("ramp2_dac", 32'(dac_data), 32'd134);
    freq_tuning_word = 32'h0;
    step();
    check("hold_dac_a", 32'(dac_data), 32'd137);
    step();
    check("hold_dac_b", 32'(dac_data), 32'd137);
    check("hold_qdac", 32'(q_dac_data), 32'd255);

    check("flag_one_cycle", 32'(flag_long), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_dds_core.md
Name: uart_tx_dds_core

Overview:
- Transmit/stimulus core combining three functions: a baud-tick generator, a UART transmitter that pops bytes from a first-word-fall-through output FIFO, and a quadrature DDS sine generator.
- Sits between the phase-detector result FIFO and the host serial line.
- Also supplies the I/Q 8-bit sine pair that drives the phase detector.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- TX_DIV, CLK_FREQ/BAUD (integer, 434), clock cycles per tx bit.
- RX_DIV, CLK_FREQ/(BAUD*16) (integer, 27), clock cycles per 16x oversample tick.

Ports:
- clk_50m  in  1  single system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- din  in  8  byte at the FIFO head; valid whenever wr_en=1.
- wr_en  in  1  FIFO non-empty (driven by ~empty).
- read_fifo_flag  out  1  one-cycle pop strobe to the FIFO.
- tx  out  1  serial line; idles high.
- tx_busy  out  1  high while a frame is in progress.
- txclk_en  out  1  one-cycle baud tick.
- rxclk_en  out  1  one-cycle 16x-baud tick.
- freq_tuning_word  in  32  DDS phase increment per clock.
- phase_accumulator_reset  in  1  synchronous clear of the DDS phase.
- dac_data  out  8  sine sample, offset binary.
- q_dac_data  out  8  cosine (quadrature) sample, offset binary.

Behaviour:
- Reset (async): both divider counters=0, txclk_en=0, rxclk_en=0, tx=1, tx_busy=0, read_fifo_flag=0, FSM=IDLE, phase=0, dac_data=128, q_dac_data=255.
- Baud generation:
  - Tx counter counts 0..TX_DIV-1 and wraps; txclk_en=1 for exactly the one cycle where the counter is 0, then every TX_DIV cycles.
  - Rx counter is independent and behaves the same with RX_DIV.
  - First txclk_en occurs on the first clock after reset release.
- Tx FSM states: IDLE, START, DATA, STOP. The FSM advances only on cycles with txclk_en=1.
  - IDLE: on a tick with wr_en=1, latch din into the shift register, pulse read_fifo_flag for that one cycle, set tx=0 and tx_busy=1, then go to START. Without wr_en, tx stays 1.
  - START: next tick drives data bit0 and goes to DATA with bit index 0.
  - DATA: each tick drives the next bit, LSB first. After bit7 has been held one bit period, the next tick drives tx=1 and goes to STOP.
  - STOP: next tick sets tx_busy=0 and goes to IDLE. wr_en is evaluated on that same tick, so back-to-back frames have no extra idle bit. Frame length is exactly 10 bit periods.
  - read_fifo_flag is never high for more than one clock and is never issued while tx_busy=1 and FSM≠STOP.
  - wr_en dropping mid-frame does not affect the frame in progress.
- DDS:
  - Each clock, phase <= phase_accumulator_reset ? 0 : phase + freq_tuning_word (mod 2^32).
  - Lookup address a = phase[31:24] of the current, pre-update phase.
  - dac_data <= S[a] and q_dac_data <= S[(a+64) mod 256], where S[k] = 128 + round(127*sin(2πk/256)). Range is 1..255.
  - Latency: outputs reflect the accumulator value one clock earlier.
  - phase_accumulator_reset has priority over accumulation. It does not force the outputs; they follow the table.
  - freq_tuning_word changes take effect on the next accumulate, with phase continuity (no jump).
  - ftw=0 holds the outputs constant.
- Reset asserted mid-frame: tx returns to 1 immediately and the byte is abandoned (no re-pop).

Test Plan:
- Hold reset low and wr_en=0, count cycles between txclk_en pulses -> exactly 434; rxclk_en every 27; tx constant 1; read_fifo_flag never asserted.
- wr_en=1, din=0xA5 for one byte -> one read_fifo_flag pulse coincident with a txclk_en. tx sequence per bit period is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 0xA5, stop), each bit 434 cycles. tx_busy high for 4340 cycles.
- wr_en held high with FIFO supplying 0x00 then 0xFF -> two consecutive frames with no idle gap and exactly two read_fifo_flag pulses, 4340 cycles apart.
- freq_tuning_word=0x40000000 after reset -> dac_data sequence 128,255,128,1 repeating; q_dac_data 255,128,1,128 repeating.
- freq_tuning_word=0x01000000 for 100 cycles, then pulse phase_accumulator_reset -> two cycles later dac_data=128, q_dac_data=255, and the ramp restarts from table index 1.
- Assert reset during data bit 3 of a frame -> tx=1 and tx_busy=0 within the same cycle; after release, no pop until the next txclk_en with wr_en=1.
